// File: rtl/line_buffer_nrow.sv
// line_buffer_nrow: N-row line buffer that turns a raster pixel stream into
// columns of ROWS vertically aligned pixels, with frame restart and flush padding.
module line_buffer_nrow #(
    parameter int unsigned       DATA_W      = 24,
    parameter int unsigned       LINE_W      = 250,
    parameter int unsigned       ROWS        = 5,
    parameter int unsigned       FLUSH_LINES = 2,
    parameter logic [DATA_W-1:0] PAD_VAL     = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sof,
    input  logic [DATA_W-1:0]      din,
    input  logic                   valid_in,
    input  logic                   flush,
    output logic [ROWS*DATA_W-1:0] col_out,
    output logic                   valid_out,
    output logic                   eol_out,
    output logic                   busy
);

    localparam int unsigned     CW        = $clog2(LINE_W);
    localparam int unsigned     LW        = $clog2(ROWS);
    localparam logic [CW-1:0]   COL_LAST  = CW'(LINE_W - 1);
    localparam logic [LW-1:0]   LINE_FULL = LW'(ROWS - 1);
    localparam logic [LW-1:0]   FL        = LW'(FLUSH_LINES);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN, S_FLUSH} state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     col_cnt, col_eff, col_nxt;
    logic [LW-1:0]     line_cnt, line_eff, line_nxt;
    logic [LW-1:0]     lines_left, lines_left_nxt;
    logic              in_flush, acc, col_wrap, clr;
    logic [DATA_W-1:0] pix;

    logic [DATA_W-1:0] mem [ROWS-1][LINE_W];

    // sof acts as an immediate counter clear, so a pixel arriving with it lands at column 0
    always_comb begin
        col_eff  = sof ? '0 : col_cnt;
        line_eff = sof ? '0 : line_cnt;
        in_flush = (state == S_FLUSH) && !sof;
        acc      = in_flush || valid_in;
        pix      = in_flush ? PAD_VAL : din;
        col_wrap = (col_eff == COL_LAST);
        col_nxt  = col_eff;
        line_nxt = line_eff;
        if (acc) begin
            col_nxt = col_wrap ? '0 : col_eff + CW'(1);
            if (col_wrap && (line_eff != LINE_FULL))
                line_nxt = line_eff + LW'(1);
        end
    end

    // Next-state logic; flush padding ends on the wrap seen with no extra lines left
    always_comb begin
        state_nxt      = state;
        lines_left_nxt = lines_left;
        clr            = 1'b0;
        if (sof) begin
            state_nxt = valid_in ? S_FILL : S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (acc)
                        state_nxt = (line_nxt == LINE_FULL) ? S_RUN : S_FILL;
                end
                S_FILL, S_RUN: begin
                    if (flush) begin
                        if ((col_nxt == '0) && (FLUSH_LINES == 0)) begin
                            state_nxt = S_IDLE;
                            clr       = 1'b1;
                        end else begin
                            state_nxt      = S_FLUSH;
                            // a partial line is padded first and consumes no extra-line credit
                            lines_left_nxt = (col_nxt == '0) ? FL - LW'(1) : FL;
                        end
                    end else if ((state == S_FILL) && (line_nxt == LINE_FULL)) begin
                        state_nxt = S_RUN;
                    end
                end
                S_FLUSH: begin
                    if (col_wrap && (lines_left == '0)) begin
                        state_nxt = S_IDLE;
                        clr       = 1'b1;
                    end else if (col_wrap) begin
                        lines_left_nxt = lines_left - LW'(1);
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // State and position counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            col_cnt    <= '0;
            line_cnt   <= '0;
            lines_left <= '0;
        end else begin
            state      <= state_nxt;
            lines_left <= lines_left_nxt;
            col_cnt    <= clr ? '0 : col_nxt;
            line_cnt   <= clr ? '0 : line_nxt;
        end
    end

    // Line RAM cascade: each RAM takes the previous RAM's old word at the same column
    always_ff @(posedge clk) begin
        if (acc) begin
            mem[0][col_eff] <= pix;
            for (int unsigned j = 1; j < ROWS - 1; j++)
                mem[j][col_eff] <= mem[j-1][col_eff];
        end
    end

    // Registered column output, valid gated until ROWS-1 complete lines are stored
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_out   <= '0;
            valid_out <= 1'b0;
            eol_out   <= 1'b0;
        end else begin
            valid_out <= acc && (line_eff == LINE_FULL);
            eol_out   <= acc && col_wrap && (line_eff == LINE_FULL);
            if (acc) begin
                col_out[DATA_W-1:0] <= pix;
                for (int unsigned k = 1; k < ROWS; k++)
                    col_out[k*DATA_W +: DATA_W] <= mem[k-1][col_eff];
            end
        end
    end

    assign busy = (state == S_FLUSH);

endmodule
